arch_map_mw: RTL and testbench
==============================

# arch_map_mw

Multi-way architectural map: holds the committed logical-to-physical register mapping, updated by up to RETIRE_W retiring instructions per cycle. Returns each retiring instruction's previous physical register (Told) to the free list. On a recovery request, streams the full committed map to the rename table over several cycles. Sits between the ROB (retire side), the free list (Told side) and the RAT (recovery copy side).

## Interface
Parameters:
- AREG_NUM, 32, number of architectural registers (power of two)
- AREG_W, $clog2(AREG_NUM), logical index width (derived)
- PREG_W, 6, physical register tag width
- RETIRE_W, 2, retire slots per cycle; slot 0 is oldest
- READ_PORTS, 2, asynchronous read ports
- COPY_W, 8, map entries per recovery beat; must divide AREG_NUM

Ports:
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high
- retire_en_i  in  RETIRE_W  per-slot retire valid
- retire_areg_idx_i  in  RETIRE_W*AREG_W  per-slot destination logical reg
- retire_preg_i  in  RETIRE_W*PREG_W  per-slot new physical reg
- told_valid_o  out  RETIRE_W  per-slot Told valid; equals the accepted retire_en_i
- told_preg_o  out  RETIRE_W*PREG_W  per-slot previous mapping, freed to the free list
- read_idx_i  in  READ_PORTS*AREG_W  read addresses
- read_data_o  out  READ_PORTS*PREG_W  registered map contents; no retire bypass
- recover_req_i  in  1  single-cycle recovery start
- recover_busy_o  out  1  copy-out in progress
- copy_valid_o  out  1  beat valid
- copy_base_o  out  AREG_W  first logical index in the beat
- copy_data_o  out  COPY_W*PREG_W  entries copy_base_o .. copy_base_o+COPY_W-1; entry 0 in the LSBs
- copy_done_o  out  1  pulses with the last beat

## Operation
- Map register file: AREG_NUM x PREG_W. On reset, entry i = i, truncated to PREG_W.
- Retire, accepted only in state IDLE:
  - All enabled slots write in the same cycle.
  - When two or more slots target the same areg, the highest-numbered (youngest) slot's preg wins.
- Told for slot k, combinational in the same cycle:
  - If an enabled slot j<k targets the same areg, Told is retire_preg_i of the highest such j.
  - Otherwise Told is the current map entry.
  - This guarantees each overwritten preg is freed exactly once.
- Slots with retire_en_i=0 have told_valid_o=0 and told_preg_o=0.
- Retire with areg 0 is treated like any other index; there is no hardwired zero.
- FSM states:
  - IDLE -> COPY on recover_req_i=1. Retires in that same cycle commit, so the copy reflects them.
  - COPY: beat counter cnt runs from 0 to AREG_NUM/COPY_W-1. copy_valid_o=1, copy_base_o=cnt*COPY_W, and copy_data_o is read from the map.
  - COPY -> IDLE after the beat where cnt = last; copy_done_o=1 on that beat.
- While in COPY:
  - retire_en_i is ignored: map unchanged, told_valid_o=0. The ROB is flushed, so this does not occur legally; the bench asserts it.
  - recover_req_i is ignored; no restart.
  - read ports stay functional.
- The map is frozen during COPY, so all beats present one consistent snapshot.
- recover_busy_o=1 exactly in COPY.
- If AREG_NUM/COPY_W = 1, COPY lasts one cycle, and copy_valid_o and copy_done_o assert together.

## Timing
- Reset values: map[i]=i, state IDLE, cnt=0, recover_busy_o=0, copy_valid_o=0, copy_done_o=0, copy_base_o=0, copy_data_o=0, told_valid_o=0.
- Reset asserted in COPY aborts immediately: no copy_done_o, and the map reinitialises next edge.
- Retire write latency: a write at edge T is visible on read_data_o after T; a read in the same cycle returns the old value.
- Told is zero-latency, combinational from the inputs and the map.
- Recovery copy:
  - recover_req_i high in cycle T (IDLE) -> beats in cycles T+1 .. T+N, where N=AREG_NUM/COPY_W.
  - copy_done_o high in cycle T+N.
  - IDLE again at T+N+1; a new recover_req_i is accepted in T+N+1.
- No backpressure: the RAT must accept every beat.

## Test plan
- Reset, then read all 32 entries -> read_data_o[i]=i; all copy outputs 0.
- Same-areg bypass (defaults): map[5]=5; in one cycle retire slot0 (areg 5, preg 40) and slot1 (areg 5, preg 41) -> told_preg_o = {40, 5}, both valid; next cycle map[5]=41.
- Distinct aregs: slot0 (3, 33) and slot1 (7, 37) -> Told = {7, 3}; then read 3 and 7 -> 33, 37.
- Recovery (COPY_W=8): at cycle T, retire (2, 50) together with recover_req_i -> beats T+1..T+4 with bases 0, 8, 16, 24; entry 2 of the first beat = 50; copy_done_o only at T+4; busy falls at T+5.
- Retire (9, 60) and a second recover_req_i during COPY -> map[9] unchanged, told_valid_o=0, no extra beats.
- rst asserted at the second copy beat -> next cycle busy=0, no copy_done_o, map[i]=i.

Source files
------------

// File: rtl/arch_map_mw.sv
// Committed logical-to-physical register map: multi-slot retire with Told return,
// and a multi-beat snapshot copy-out to the rename table on recovery.
module arch_map_mw #(
    parameter int unsigned AREG_NUM   = 32,
    parameter int unsigned AREG_W     = $clog2(AREG_NUM),
    parameter int unsigned PREG_W     = 6,
    parameter int unsigned RETIRE_W   = 2,
    parameter int unsigned READ_PORTS = 2,
    parameter int unsigned COPY_W     = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [RETIRE_W-1:0]            retire_en_i,
    input  logic [RETIRE_W*AREG_W-1:0]     retire_areg_idx_i,
    input  logic [RETIRE_W*PREG_W-1:0]     retire_preg_i,
    output logic [RETIRE_W-1:0]            told_valid_o,
    output logic [RETIRE_W*PREG_W-1:0]     told_preg_o,
    input  logic [READ_PORTS*AREG_W-1:0]   read_idx_i,
    output logic [READ_PORTS*PREG_W-1:0]   read_data_o,
    input  logic                           recover_req_i,
    output logic                           recover_busy_o,
    output logic                           copy_valid_o,
    output logic [AREG_W-1:0]              copy_base_o,
    output logic [COPY_W*PREG_W-1:0]       copy_data_o,
    output logic                           copy_done_o
);

    localparam int unsigned NUM_BEATS = AREG_NUM / COPY_W;
    localparam int unsigned CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    typedef enum logic {StIdle, StCopy} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PREG_W-1:0]  map_q [AREG_NUM];
    logic [PREG_W-1:0]  map_d [AREG_NUM];
    logic               retire_ok;
    logic [AREG_W-1:0]  beat_base;

    assign retire_ok = (state_q == StIdle);
    assign beat_base = AREG_W'(32'(cnt_q) * COPY_W);

    // Told: an older same-cycle slot to the same areg supersedes the map entry.
    always_comb begin
        told_valid_o = '0;
        told_preg_o  = '0;
        for (int k = 0; k < RETIRE_W; k++) begin
            if (retire_ok && retire_en_i[k]) begin
                told_valid_o[k] = 1'b1;
                told_preg_o[k*PREG_W +: PREG_W] = map_q[retire_areg_idx_i[k*AREG_W +: AREG_W]];
                for (int j = 0; j < k; j++) begin
                    if (retire_en_i[j] &&
                        retire_areg_idx_i[j*AREG_W +: AREG_W] ==
                        retire_areg_idx_i[k*AREG_W +: AREG_W]) begin
                        told_preg_o[k*PREG_W +: PREG_W] = retire_preg_i[j*PREG_W +: PREG_W];
                    end
                end
            end
        end
    end

    // Ascending slot order lets the youngest slot win on a collision.
    always_comb begin
        map_d = map_q;
        if (retire_ok) begin
            for (int k = 0; k < RETIRE_W; k++) begin
                if (retire_en_i[k]) begin
                    map_d[retire_areg_idx_i[k*AREG_W +: AREG_W]] = retire_preg_i[k*PREG_W +: PREG_W];
                end
            end
        end
    end

    always_comb begin
        read_data_o = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            read_data_o[p*PREG_W +: PREG_W] = map_q[read_idx_i[p*AREG_W +: AREG_W]];
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        recover_busy_o = 1'b0;
        copy_valid_o   = 1'b0;
        copy_base_o    = '0;
        copy_data_o    = '0;
        copy_done_o    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (recover_req_i) begin
                    state_d = StCopy;
                    cnt_d   = '0;
                end
            end
            StCopy: begin
                recover_busy_o = 1'b1;
                copy_valid_o   = 1'b1;
                copy_base_o    = beat_base;
                for (int e = 0; e < COPY_W; e++) begin
                    copy_data_o[e*PREG_W +: PREG_W] = map_q[beat_base + AREG_W'(e)];
                end
                if (cnt_q == CNT_W'(NUM_BEATS - 1)) begin
                    copy_done_o = 1'b1;
                    state_d     = StIdle;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            for (int i = 0; i < AREG_NUM; i++) begin
                map_q[i] <= PREG_W'(i);
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            map_q   <= map_d;
        end
    end

endmodule

// File: tb/tb_arch_map_mw.sv
// Directed bench for arch_map_mw: reference map model plus a queue of expected copy beats.
module tb_arch_map_mw;

    localparam int AN = 32;
    localparam int AW = 5;
    localparam int PW = 6;
    localparam int CW = 8;
    localparam int NB = AN / CW;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      retire_en;
    logic [2*AW-1:0] retire_idx;
    logic [2*PW-1:0] retire_preg;
    logic [1:0]      told_valid;
    logic [2*PW-1:0] told_preg;
    logic [2*AW-1:0] read_idx;
    logic [2*PW-1:0] read_data;
    logic            recover_req;
    logic            busy;
    logic            copy_valid;
    logic [AW-1:0]   copy_base;
    logic [CW*PW-1:0] copy_data;
    logic            copy_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [PW-1:0]    model [AN];
    logic [AW-1:0]    exp_base_q [$];
    logic [CW*PW-1:0] exp_data_q [$];
    logic             exp_done_q [$];

    arch_map_mw dut (
        .clk               (clk),
        .rst               (rst),
        .retire_en_i       (retire_en),
        .retire_areg_idx_i (retire_idx),
        .retire_preg_i     (retire_preg),
        .told_valid_o      (told_valid),
        .told_preg_o       (told_preg),
        .read_idx_i        (read_idx),
        .read_data_o       (read_data),
        .recover_req_i     (recover_req),
        .recover_busy_o    (busy),
        .copy_valid_o      (copy_valid),
        .copy_base_o       (copy_base),
        .copy_data_o       (copy_data),
        .copy_done_o       (copy_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < AN; i++) model[i] = PW'(i);
    endtask

    function automatic logic [CW*PW-1:0] pack_beat(input int base);
        logic [CW*PW-1:0] d = '0;
        for (int e = 0; e < CW; e++) d[e*PW +: PW] = model[base + e];
        return d;
    endfunction

    task automatic push_snapshot();
        for (int b = 0; b < NB; b++) begin
            exp_base_q.push_back(AW'(b * CW));
            exp_data_q.push_back(pack_beat(b * CW));
            exp_done_q.push_back(b == NB - 1);
        end
    endtask

    task automatic check_beat();
        chk("beat_busy", 64'(busy), 64'd1);
        chk("beat_valid", 64'(copy_valid), 64'd1);
        chk("beat_expected", 64'(exp_base_q.size() != 0), 64'd1);
        if (exp_base_q.size() != 0) begin
            chk("beat_base", 64'(copy_base), 64'(exp_base_q.pop_front()));
            chk("beat_data", 64'(copy_data), 64'(exp_data_q.pop_front()));
            chk("beat_done", 64'(copy_done), 64'(exp_done_q.pop_front()));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_valid"}, 64'(copy_valid), 64'd0);
        chk({tag, "_done"}, 64'(copy_done), 64'd0);
        chk({tag, "_base"}, 64'(copy_base), 64'd0);
        chk({tag, "_data"}, 64'(copy_data), 64'd0);
    endtask

    task automatic read2(input int a0, input int a1);
        read_idx = {AW'(a1), AW'(a0)};
        #1;
        chk("rd_p0", 64'(read_data[PW-1:0]), 64'(model[a0]));
        chk("rd_p1", 64'(read_data[2*PW-1:PW]), 64'(model[a1]));
    endtask

    initial begin
        rst = 1'b1; retire_en = '0; retire_idx = '0; retire_preg = '0;
        read_idx = '0; recover_req = 1'b0;
        model_reset();
        tick(); tick();
        check_idle_outputs("rst");
        chk("rst_told_valid", 64'(told_valid), 64'd0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < AN; i++) read2(i, AN - 1 - i);

        // Same-areg pair: slot1 Told is slot0's preg, slot1 wins the map.
        retire_en = 2'b11; retire_idx = {AW'(5), AW'(5)}; retire_preg = {PW'(41), PW'(40)};
        read_idx = {AW'(0), AW'(5)};
        #1;
        chk("same_told_valid", 64'(told_valid), 64'h3);
        chk("same_told_preg", 64'(told_preg), 64'({PW'(40), PW'(5)}));
        chk("same_read_old", 64'(read_data[PW-1:0]), 64'd5);
        tick();
        retire_en = '0;
        model[5] = 41;
        read2(5, 4);

        retire_en = 2'b11; retire_idx = {AW'(7), AW'(3)}; retire_preg = {PW'(37), PW'(33)};
        #1;
        chk("dist_told_preg", 64'(told_preg), 64'({PW'(7), PW'(3)}));
        tick();
        retire_en = '0;
        model[3] = 33; model[7] = 37;
        read2(3, 7);

        // Disabled slot1 carries garbage; areg 0 is an ordinary entry.
        retire_en = 2'b01; retire_idx = {AW'(9), AW'(0)}; retire_preg = {PW'(63), PW'(20)};
        #1;
        chk("dis_told_valid", 64'(told_valid), 64'h1);
        chk("dis_told_preg", 64'(told_preg), 64'({PW'(0), PW'(0)}));
        tick();
        retire_en = '0;
        model[0] = 20;
        read2(0, 9);

        // Retire in the recovery-request cycle lands in the snapshot.
        recover_req = 1'b1;
        retire_en = 2'b01; retire_idx = {AW'(0), AW'(2)}; retire_preg = {PW'(0), PW'(50)};
        #1;
        chk("rec_told_valid", 64'(told_valid), 64'h1);
        chk("rec_told_preg", 64'(told_preg[PW-1:0]), 64'd2);
        model[2] = 50;
        push_snapshot();
        tick();
        recover_req = 1'b0; retire_en = '0;
        for (int i = 0; i < NB; i++) begin
            check_beat();
            if (i == 1) begin
                retire_en = 2'b01; retire_idx = {AW'(0), AW'(9)}; retire_preg = {PW'(0), PW'(60)};
                recover_req = 1'b1;
                read_idx = {AW'(9), AW'(2)};
                #1;
                chk("copy_told_valid", 64'(told_valid), 64'd0);
                chk("copy_read", 64'(read_data[PW-1:0]), 64'd50);
            end
            tick();
            retire_en = '0; recover_req = 1'b0;
        end
        check_idle_outputs("post_copy");
        chk("beats_left", 64'(exp_base_q.size()), 64'd0);
        read2(9, 2);
        tick();
        chk("no_extra_beat", 64'(copy_valid), 64'd0);

        // Reset mid-copy aborts without done and restores the identity map.
        recover_req = 1'b1;
        push_snapshot();
        tick();
        recover_req = 1'b0;
        check_beat();
        tick();
        check_beat();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_base_q.delete(); exp_data_q.delete(); exp_done_q.delete();
        model_reset();
        check_idle_outputs("abort");
        read2(5, 2);
        read2(0, 3);
        tick();
        chk("abort_no_done", 64'(copy_done), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
